bus_gate_arbiter: RTL and testbench
===================================

# bus_gate_arbiter

Sequential arbiter for the shared 16-bit datapath bus. It takes bus requests from the four gated sources (MARMUX, PC, MDR, ALU) and drives their one-hot gate enables. Only one source ever drives the bus, ownership rotates round-robin, and a configurable idle gap separates different owners. It sits between the control sequencer, which raises requests, and the bus mux, which consumes the gate signals.

## Interface
- MAX_HOLD, 4: maximum consecutive granted cycles for one owner while another requester is waiting; legal range ≥1.
- TURNAROUND, 1: idle cycles, all gates low, inserted between two different owners; legal range 0..3.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  4  per-source bus request: bit0 MARMUX, bit1 PC, bit2 MDR, bit3 ALU. Level-sensitive; the source holds it high while it wants the bus.
- GateMARMUX, GatePC, GateMDR, GateALU  output  1 each  registered one-hot gate enables (Grant bits 0..3).
- Bus_owner  output  2  index of the current owner; 0 when idle.
- Bus_valid  output  1  high iff any gate is high.

## Operation
- State machine: IDLE, GRANT, TURN.
- Round-robin pointer ptr (2 bits). The winner is the first set Req bit scanning ptr, ptr+1, … mod 4. On every new grant, ptr ← owner+1 mod 4.
- IDLE
  - All gates low.
  - If any Req bit is set: grant the winner, load hold_cnt ← 1, go to GRANT.
- GRANT (owner o)
  - Retain the grant while Req[o]=1 and not preempted; hold_cnt increments and saturates at MAX_HOLD.
  - Preemption occurs when hold_cnt=MAX_HOLD and some Req[j]=1 for j≠o. If no other requester is waiting, o keeps the bus indefinitely.
  - Release occurs on Req[o]=0 or on preemption. Next state on release:
    - Other requests pending and TURNAROUND=0: grant the next winner directly. Back-to-back grants are allowed only when TURNAROUND=0.
    - Other requests pending and TURNAROUND>0: go to TURN with tcnt ← TURNAROUND.
    - None pending: go to IDLE.
  - The preempted owner is never re-granted in the same arbitration if another Req is set (ptr has already moved past it).
- TURN
  - All gates low; tcnt decrements each cycle.
  - At tcnt=1: if any Req is set, grant the winner (sampled in this final cycle) and go to GRANT; otherwise go to IDLE.
  - Requests that drop during TURN are not granted.
- Invariants
  - At most one gate is high in any cycle.
  - Gates change only on clock edges.
  - Bus_valid = OR of the gates.
- Reset (asserted low, asynchronous, including mid-grant or mid-TURN)
  - All gates 0, Bus_owner 0, Bus_valid 0.
  - State IDLE, ptr 0, hold_cnt 0, tcnt 0.
  - First arbitration occurs on the first rising edge after deassertion.

## Timing
- Request to grant from IDLE: Req sampled at edge n → gate high in cycle n+1 (latency 1).
- Release: Req[o] low at edge n → gate low in cycle n+1.
- Owner handover with TURNAROUND=T>0: gate A low for exactly T cycles, then gate B high.
- Owner handover with T=0: gate B high in the cycle immediately after gate A's last cycle.
- Preemption: with contention, an owner holds the bus for exactly MAX_HOLD cycles.
- Same-cycle requests: resolved by ptr in a single edge; there are no combinational paths from Req to the gates.

## Test plan
- Reset, then Req=4'b0000 for 5 cycles → all gates 0, Bus_valid 0, Bus_owner 0.
- Req=4'b0110 held, T=1, MAX_HOLD=4:
  - GatePC high for cycles 1–4, 1 idle cycle, then GateMDR high for 4 cycles, then 1 idle cycle.
  - Alternation PC/MDR continues; never two gates high.
- Only Req[3]=1 for 20 cycles → GateALU high continuously from cycle 1 (no preemption); Req[3] dropped → GateALU low next cycle, state IDLE.
- T=0, Req=4'b1111 → grants MARMUX, PC, MDR, ALU, MARMUX…, each for 4 cycles, with zero gap between owners.
- GatePC high, then Req[1] dropped while Req[0]=1 → GatePC low; exactly T idle cycles; then GateMARMUX high.
- Reset asserted asynchronously mid-grant (not on an edge) → gates drop immediately. After release, with Req=4'b1000 held → GateALU high one cycle after the first edge, and ptr has restarted at 0.

Source files
------------

// File: rtl/bus_gate_arbiter_if.sv
// Request/gate bundle shared by the control sequencer, the arbiter and the bus mux.
// The arbiter takes the master view; the requesting side takes the slave view.
interface bus_gate_arbiter_if;
  logic [3:0] Req;
  logic       GateMARMUX;
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic [1:0] Bus_owner;
  logic       Bus_valid;

  modport master (
    input  Req,
    output GateMARMUX,
    output GatePC,
    output GateMDR,
    output GateALU,
    output Bus_owner,
    output Bus_valid
  );

  modport slave (
    output Req,
    input  GateMARMUX,
    input  GatePC,
    input  GateMDR,
    input  GateALU,
    input  Bus_owner,
    input  Bus_valid
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner arbiter for the 16-bit datapath bus: one-hot registered gate
// enables, bounded hold under contention and an optional idle gap between owners.
module bus_gate_arbiter #(
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  bus_gate_arbiter_if.master  bus
);

  localparam int              HW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [1:0]      TURN_LOAD = 2'(TURNAROUND);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      tcnt_q, tcnt_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      own_q, own_d;

  logic [3:0]      others;
  logic [2:0]      win_all;
  logic [2:0]      win_oth;
  logic            preempt;
  logic            do_grant;
  logic [1:0]      grant_idx;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign others  = bus.Req & ~(4'b0001 << own_q);
  assign win_all = pick(bus.Req, ptr_q);
  assign win_oth = pick(others, ptr_q);
  assign preempt = (hold_q == HOLD_MAX) && (|others);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    grant_d   = grant_q;
    own_d     = own_q;
    do_grant  = 1'b0;
    grant_idx = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        grant_d = 4'b0000;
        if (win_all[2]) begin
          do_grant  = 1'b1;
          grant_idx = win_all[1:0];
        end
      end

      S_GRANT: begin
        if (bus.Req[own_q] && !preempt) begin
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
          end
        end else if (|others) begin
          // The old owner is masked out, so a back-to-back handover never re-picks it.
          if (TURNAROUND == 0) begin
            do_grant  = 1'b1;
            grant_idx = win_oth[1:0];
          end else begin
            state_d = S_TURN;
            tcnt_d  = TURN_LOAD;
            grant_d = 4'b0000;
          end
        end else begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          hold_d  = '0;
        end
      end

      S_TURN: begin
        grant_d = 4'b0000;
        if (tcnt_q <= 2'd1) begin
          tcnt_d = 2'd0;
          if (win_all[2]) begin
            do_grant  = 1'b1;
            grant_idx = win_all[1:0];
          end else begin
            state_d = S_IDLE;
            hold_d  = '0;
          end
        end else begin
          tcnt_d = tcnt_q - 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase

    if (do_grant) begin
      state_d = S_GRANT;
      grant_d = 4'b0001 << grant_idx;
      own_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
      hold_d  = HOLD_ONE;
      tcnt_d  = 2'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      tcnt_q  <= 2'd0;
      grant_q <= 4'b0000;
      own_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
      own_q   <= own_d;
    end
  end

  assign bus.GateMARMUX = grant_q[0];
  assign bus.GatePC     = grant_q[1];
  assign bus.GateMDR    = grant_q[2];
  assign bus.GateALU    = grant_q[3];
  // Owner is encoded straight from the one-hot gates so it reads 0 whenever the bus is idle.
  assign bus.Bus_owner  = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
  assign bus.Bus_valid  = |grant_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter: one instance with a 1-cycle gap and one
// with back-to-back handover, both with a hold limit of 4 cycles.
module tb_bus_gate_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_gate_arbiter_if bus1();
  bus_gate_arbiter_if bus0();

  bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(1)) dut_t1 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus1)
  );

  bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(0)) dut_t0 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus0)
  );

  logic [3:0] g1, g0;
  assign g1 = {bus1.GateALU, bus1.GateMDR, bus1.GatePC, bus1.GateMARMUX};
  assign g0 = {bus0.GateALU, bus0.GateMDR, bus0.GatePC, bus0.GateMARMUX};

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] MAR  = 4'b0001;
  localparam logic [3:0] PC   = 4'b0010;
  localparam logic [3:0] MDR  = 4'b0100;
  localparam logic [3:0] ALU  = 4'b1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks gates, owner and valid of one instance against the expected gate pattern.
  task automatic check_bus(input string tag, input logic [3:0] g, input logic [1:0] own,
                           input logic vld, input logic [3:0] exp_g);
    logic [1:0] exp_own;
    case (exp_g)
      PC:      exp_own = 2'd1;
      MDR:     exp_own = 2'd2;
      ALU:     exp_own = 2'd3;
      default: exp_own = 2'd0;
    endcase
    check({tag, ".gates"}, 32'(g), 32'(exp_g));
    check({tag, ".owner"}, 32'(own), 32'(exp_own));
    check({tag, ".valid"}, 32'(vld), 32'(|exp_g));
    $display("txn %-12s gates=%b owner=%0d valid=%b (want %b)", tag, g, own, vld, exp_g);
  endtask

  task automatic chk1(input string tag, input logic [3:0] exp_g);
    check_bus(tag, g1, bus1.Bus_owner, bus1.Bus_valid, exp_g);
  endtask

  task automatic chk0(input string tag, input logic [3:0] exp_g);
    check_bus(tag, g0, bus0.Bus_owner, bus0.Bus_valid, exp_g);
  endtask

  // PC/MDR alternation with a 1-cycle gap and a 4-cycle hold.
  logic [3:0] alt_exp [14] = '{PC, PC, PC, PC, NONE, MDR, MDR, MDR, MDR, NONE, PC, PC, PC, PC};

  initial begin
    rst_n    = 1'b0;
    bus1.Req = 4'b0000;
    bus0.Req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_t1", NONE);
    chk0("rst_t0", NONE);
    rst_n = 1'b1;

    // Idle bus stays idle.
    for (int k = 0; k < 5; k++) begin
      step();
      chk1($sformatf("idle%0d", k), NONE);
    end

    // Two contenders alternate, each for exactly MAX_HOLD cycles.
    bus1.Req = 4'b0110;
    for (int k = 0; k < 14; k++) begin
      step();
      chk1($sformatf("alt%0d", k + 1), alt_exp[k]);
    end
    bus1.Req = 4'b0000;
    step();
    chk1("alt_drop", NONE);

    // A lone requester is never preempted.
    bus1.Req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      step();
      chk1($sformatf("solo%0d", k + 1), ALU);
    end
    bus1.Req = 4'b0000;
    step();
    chk1("solo_drop", NONE);
    step();
    chk1("solo_idle", NONE);

    // Release by the owner hands over after exactly one idle cycle.
    bus1.Req = 4'b0010;
    step();
    chk1("rel_pc", PC);
    bus1.Req = 4'b0001;
    step();
    chk1("rel_gap", NONE);
    step();
    chk1("rel_mar", MAR);
    bus1.Req = 4'b0000;
    step();
    chk1("rel_drop", NONE);

    // Zero turnaround: full rotation with no gaps.
    bus0.Req = 4'b1111;
    for (int k = 0; k < 18; k++) begin
      step();
      chk0($sformatf("rr%0d", k + 1), 4'b0001 << ((k / 4) % 4));
    end
    bus0.Req = 4'b0000;
    step();
    chk0("rr_drop", NONE);

    // Asynchronous reset mid-grant, then ALU regains the bus on the first edge.
    bus1.Req = 4'b1000;
    step();
    chk1("ar_alu", ALU);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_in_rst", NONE);
    #2 rst_n = 1'b1;
    step();
    chk1("ar_regrant", ALU);

    // Pointer restarts at 0: with PC and MDR both requesting, PC must win.
    bus1.Req = 4'b0000;
    step();
    chk1("ptr_idle", NONE);
    bus1.Req = 4'b0010;
    step();
    chk1("ptr_pc", PC);
    #2 rst_n = 1'b0;
    bus1.Req = 4'b0110;
    #1;
    chk1("ptr_in_rst", NONE);
    #2 rst_n = 1'b1;
    step();
    chk1("ptr_first", PC);
    bus1.Req = 4'b0000;
    step();
    chk1("ptr_drop", NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
